temp_to_bcd: RTL and testbench



---
 rtl/temp_to_bcd.sv | 151 +++++++++++++++
 tb/tb_temp_to_bcd.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/temp_to_bcd.sv
// rtl/temp_to_bcd.sv - TMP121 word to four 7-segment digit codes (d3 d2 d1.d0)
// Sequential double-dabble conversion of the temperature in tenths of a degree.
module temp_to_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dout0,
  output logic [3:0]  dout1,
  output logic [3:0]  dout2,
  output logic [3:0]  dout3
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    SHIFT  = 2'd2,
    FORMAT = 2'd3
  } state_t;

  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] LAST_SHIFT = 4'd11;

  state_t state;
  state_t state_next;

  logic [12:0] t;
  logic        neg;
  logic        sat;
  logic [11:0] bin;
  logic [15:0] bcd;
  logic [3:0]  cnt;

  logic [12:0] mag;
  logic [12:0] q;
  logic        q_sat;
  logic [15:0] bcd_adj;
  logic [27:0] shifted;
  logic [3:0]  h;
  logic [3:0]  tn;
  logic [3:0]  u;
  logic [3:0]  f;
  logic [15:0] fmt;

  logic unused_din_lsbs;
  assign unused_din_lsbs = ^din[2:0];

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (din_valid) state_next = CALC;
      CALC:    state_next = SHIFT;
      SHIFT:   if (cnt == LAST_SHIFT) state_next = FORMAT;
      FORMAT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // |T| fits 13 bits unsigned even for -4096; q is rounded tenths of a degree
  always_comb begin
    mag   = t[12] ? (~t + 13'd1) : t;
    q     = 13'(({4'b0000, mag} * 17'd10 + 17'd8) >> 4);
    q_sat = (q > 13'd2559) || (t[12] && (q > 13'd999));
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin} << 1;
  end

  // negatives never reach hundreds, so the minus sign takes the tens or hundreds slot
  always_comb begin
    h  = bcd[15:12];
    tn = bcd[11:8];
    u  = bcd[7:4];
    f  = bcd[3:0];
    fmt = {DIG_BLANK, DIG_BLANK, u, f};
    if (sat) begin
      fmt = {DIG_MINUS, 4'd9, 4'd9, 4'd9};
    end else if (neg) begin
      if (tn != 4'd0) begin
        fmt = {DIG_MINUS, tn, u, f};
      end else begin
        fmt = {DIG_BLANK, DIG_MINUS, u, f};
      end
    end else begin
      fmt[15:12] = (h != 4'd0) ? h : DIG_BLANK;
      fmt[11:8]  = ((h != 4'd0) || (tn != 4'd0)) ? tn : DIG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t     <= '0;
      neg   <= 1'b0;
      sat   <= 1'b0;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout3 <= DIG_MINUS;
      dout2 <= DIG_MINUS;
      dout1 <= DIG_MINUS;
      dout0 <= DIG_MINUS;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (din_valid) t <= din[15:3];
        end
        CALC: begin
          neg <= t[12];
          sat <= q_sat;
          bin <= q[11:0];
          bcd <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          bcd <= shifted[27:12];
          bin <= shifted[11:0];
          cnt <= cnt + 4'd1;
        end
        FORMAT: begin
          {dout3, dout2, dout1, dout0} <= fmt;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_to_bcd.sv
// tb/tb_temp_to_bcd.sv - scoreboard bench for temp_to_bcd
module tb_temp_to_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [3:0]  dout0;
  logic [3:0]  dout1;
  logic [3:0]  dout2;
  logic [3:0]  dout3;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  localparam int NVEC = 17;
  logic [15:0] vec_din[NVEC];
  logic [15:0] vec_exp[NVEC];

  temp_to_bcd dut (
    .clk(clk),
    .rst(rst),
    .din_valid(din_valid),
    .din(din),
    .busy(busy),
    .done(done),
    .dout0(dout0),
    .dout1(dout1),
    .dout2(dout2),
    .dout3(dout3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got digits %0h expected no done", {dout3, dout2, dout1, dout0});
      end else begin
        check("digits", {dout3, dout2, dout1, dout0}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic convert(input logic [15:0] word, input logic [15:0] expd);
    int n;
    @(negedge clk);
    din = word;
    din_valid = 1'b1;
    exp_q.push_back(expd);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    check("busy_after_capture", busy, 1);
    wait_done(n);
    check("latency", n, 14);
    check("busy_at_done", busy, 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int n;
    vec_din = '{16'h0C80, 16'hFAF8, 16'hFFF8, 16'h0000, 16'h7FF8, 16'h8000,
                16'hCE00, 16'hCE08, 16'h0080, 16'h0008, 16'h3E80, 16'h3208,
                16'hFF80, 16'h0018, 16'h0C87, 16'hFB00, 16'h0C80};
    vec_exp = '{16'hF250, 16'hA101, 16'hFA01, 16'hFF00, 16'h2559, 16'hA999,
                16'hA999, 16'hA999, 16'hFF10, 16'hFF01, 16'h1250, 16'h1001,
                16'hFA10, 16'hFF02, 16'hF250, 16'hA100, 16'hF250};

    rst = 1'b1;
    din_valid = 1'b0;
    din = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_digits", {dout3, dout2, dout1, dout0}, 16'hAAAA);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      convert(vec_din[i], vec_exp[i]);
    end

    // a second strobe while busy must be dropped
    @(negedge clk);
    din = 16'h0C80;
    din_valid = 1'b1;
    exp_q.push_back(16'hF250);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    din = 16'hFFF8;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    check("busy_ignores_strobe", busy, 1);
    wait_done(n);
    check("ignored_latency", n, 9);
    repeat (20) @(posedge clk);
    #1;
    check("ignored_no_second", exp_q.size(), 0);
    check("ignored_digits_hold", {dout3, dout2, dout1, dout0}, 16'hF250);

    // reset mid-SHIFT abandons the conversion
    @(negedge clk);
    din = 16'h7FF8;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_digits", {dout3, dout2, dout1, dout0}, 16'hAAAA);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midreset_idle_busy", busy, 0);
    check("midreset_idle_digits", {dout3, dout2, dout1, dout0}, 16'hAAAA);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
